// File: rtl/id_pkg.sv
// Shared definitions for the pipelined instruction-decode stage.
// Build option: IDSTAGE_IMM_ZEXT_EN adds ANDI/ORI decoding (logic ALU class).
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(9'd0);

    // Main control decoder; unknown opcodes fall through as NOPs.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
`ifdef IDSTAGE_IMM_ZEXT_EN
            OP_ANDI, OP_ORI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_LOGIC;
            end
`endif
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage: two async read ports with write-through
// bypass, one synchronous write port, entry 0 hard-wired to zero.
module id_regfile
    import id_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] raddr1_i,
    input  logic [W-1:0] raddr2_i,
    output logic [B-1:0] rdata1_o,
    output logic [B-1:0] rdata2_o,
    input  logic         we_i,
    input  logic [W-1:0] waddr_i,
    input  logic [B-1:0] wdata_i
);

    localparam int DEPTH = 32'd1 << W;

    logic [B-1:0] mem_q [DEPTH];
    logic         wr_en_s;

    assign wr_en_s = we_i && (waddr_i != {W{1'b0}});

    // Storage: cleared on reset, written on any qualified writeback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {B{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: zero register first, then same-cycle writeback bypass.
    always_comb begin
        if (raddr1_i == {W{1'b0}}) begin
            rdata1_o = {B{1'b0}};
        end else if (wr_en_s && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = mem_q[raddr1_i];
        end
        if (raddr2_i == {W{1'b0}}) begin
            rdata2_o = {B{1'b0}};
        end else if (wr_en_s && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = mem_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// Pipelined decode stage: decodes one instruction per handshake into an
// ID/EX register with valid/ready flow control, load-use stall and flush.
// Build option: IDSTAGE_IMM_ZEXT_EN zero-extends ANDI/ORI immediates.
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [B-1:0] instruction,
    input  logic [B-1:0] pc_plus4_in,
    input  logic         flush,
    input  logic         wb_reg_write,
    input  logic [W-1:0] wb_addr,
    input  logic [B-1:0] wb_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [B-1:0] reg_data1,
    output logic [B-1:0] reg_data2,
    output logic [B-1:0] imm_ext,
    output logic [W-1:0] rs,
    output logic [W-1:0] rt,
    output logic [W-1:0] rd,
    output logic [B-1:0] pc_plus4_out,
    output logic         wb_RegWrite_out,
    output logic         wb_MemtoReg_out,
    output logic         m_Branch_out,
    output logic         m_MemRead_out,
    output logic         m_MemWrite_out,
    output logic         ex_RegDst_out,
    output logic         ex_ALUSrc_out,
    output logic [1:0]   ex_ALUOp_out,
    output logic         hazard_stall
);

    logic [5:0]   opcode_s;
    logic [W-1:0] rs_s, rt_s, rd_s;
    logic [B-1:0] rd1_s, rd2_s, imm_s;
    ctrl_t        ctrl_s;
    logic         zext_s, accept_s;

    logic         valid_q, valid_d;
    ctrl_t        ctrl_q, ctrl_d;
    logic [B-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

    assign opcode_s = instruction[31:26];
    assign rs_s     = W'(instruction[25:21]);
    assign rt_s     = W'(instruction[20:16]);
    assign rd_s     = W'(instruction[15:11]);
    assign ctrl_s   = decode_ctrl(opcode_s);

`ifdef IDSTAGE_IMM_ZEXT_EN
    assign zext_s = (opcode_s == OP_ANDI) || (opcode_s == OP_ORI);
`else
    assign zext_s = 1'b0;
`endif

    // Immediate extension: zero-extend logic immediates, sign-extend the rest.
    always_comb begin
        if (zext_s) begin
            imm_s = {{(B-16){1'b0}}, instruction[15:0]};
        end else begin
            imm_s = {{(B-16){instruction[15]}}, instruction[15:0]};
        end
    end

    id_regfile #(.B(B), .W(W)) u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset),
        .raddr1_i (rs_s),
        .raddr2_i (rt_s),
        .rdata1_o (rd1_s),
        .rdata2_o (rd2_s),
        .we_i     (wb_reg_write),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // Load-use hazard: the load in ID/EX targets a source of the incoming instr.
    assign hazard_stall = in_valid && valid_q && ctrl_q.mem_read &&
                          (rt_q != {W{1'b0}}) && ((rt_q == rs_s) || (rt_q == rt_s));
    assign in_ready     = flush || (!hazard_stall && (!valid_q || out_ready));
    assign accept_s     = in_valid && in_ready && !flush;

    // ID/EX next state: flush beats accept, accept beats drain, else hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_s;
            rd1_d   = rd1_s;
            rd2_d   = rd2_s;
            imm_d   = imm_s;
            pc_d    = pc_plus4_in;
            rs_d    = rs_s;
            rt_d    = rt_s;
            rd_d    = rd_s;
        end else if (out_ready && valid_q) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            rd1_q   <= {B{1'b0}};
            rd2_q   <= {B{1'b0}};
            imm_q   <= {B{1'b0}};
            pc_q    <= {B{1'b0}};
            rs_q    <= {W{1'b0}};
            rt_q    <= {W{1'b0}};
            rd_q    <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid       = valid_q;
    assign reg_data1       = rd1_q;
    assign reg_data2       = rd2_q;
    assign imm_ext         = imm_q;
    assign pc_plus4_out    = pc_q;
    assign rs              = rs_q;
    assign rt              = rt_q;
    assign rd              = rd_q;
    assign wb_RegWrite_out = ctrl_q.reg_write;
    assign wb_MemtoReg_out = ctrl_q.mem_to_reg;
    assign m_Branch_out    = ctrl_q.branch;
    assign m_MemRead_out   = ctrl_q.mem_read;
    assign m_MemWrite_out  = ctrl_q.mem_write;
    assign ex_RegDst_out   = ctrl_q.reg_dst;
    assign ex_ALUSrc_out   = ctrl_q.alu_src;
    assign ex_ALUOp_out    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed scoreboard bench for id_stage_pipelined.
module tb_id_stage_pipelined;

    localparam int B = 32;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, flush, wb_reg_write, out_valid, out_ready;
    logic [B-1:0] instruction, pc_plus4_in, wb_data;
    logic [W-1:0] wb_addr, rs, rt, rd;
    logic [B-1:0] reg_data1, reg_data2, imm_ext, pc_plus4_out;
    logic         wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out;
    logic         m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out, hazard_stall;
    logic [1:0]   ex_ALUOp_out;
    logic [8:0]   dut_ctrl;

    always #5 clk = ~clk;

    id_stage_pipelined #(.B(B), .W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_plus4_in(pc_plus4_in), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_data1(reg_data1), .reg_data2(reg_data2), .imm_ext(imm_ext),
        .rs(rs), .rt(rt), .rd(rd), .pc_plus4_out(pc_plus4_out),
        .wb_RegWrite_out(wb_RegWrite_out), .wb_MemtoReg_out(wb_MemtoReg_out),
        .m_Branch_out(m_Branch_out), .m_MemRead_out(m_MemRead_out),
        .m_MemWrite_out(m_MemWrite_out), .ex_RegDst_out(ex_RegDst_out),
        .ex_ALUSrc_out(ex_ALUSrc_out), .ex_ALUOp_out(ex_ALUOp_out),
        .hazard_stall(hazard_stall)
    );

    // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[1:0]}
    assign dut_ctrl = {wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
                       m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out};

    typedef struct {
        logic [31:0] d1, d2, imm, pc;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mrf [32];
    logic        m_valid;
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [8:0] model_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b100001010;
            6'b100011: return 9'b110100100;
            6'b101011: return 9'b000010100;
            6'b000100: return 9'b001000001;
            6'b001000: return 9'b100000100;
`ifdef IDSTAGE_IMM_ZEXT_EN
            6'b001100: return 9'b100000111;
            6'b001101: return 9'b100000111;
`endif
            default:   return 9'b000000000;
        endcase
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        logic z;
        z = 1'b0;
`ifdef IDSTAGE_IMM_ZEXT_EN
        z = (ins[31:26] == 6'b001100) || (ins[31:26] == 6'b001101);
`endif
        return z ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_reg_write && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        in_valid    = 1'b1;
        instruction = ins;
        pc_plus4_in = pc;
    endtask

    // One clock of the scoreboard model: predict handshake, advance, compare.
    task automatic tick();
        logic stl, rdy, acc;
        exp_t e;
        #1;
        stl = in_valid && m_valid && q[0].ctrl[5] && (q[0].rt != 5'd0) &&
              ((q[0].rt == instruction[25:21]) || (q[0].rt == instruction[20:16]));
        rdy = flush || (!stl && (!m_valid || out_ready));
        acc = in_valid && rdy && !flush;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, stl});
        if (acc) begin
            e.d1   = model_read(instruction[25:21]);
            e.d2   = model_read(instruction[20:16]);
            e.imm  = model_imm(instruction);
            e.pc   = pc_plus4_in;
            e.rs   = instruction[25:21];
            e.rt   = instruction[20:16];
            e.rd   = instruction[15:11];
            e.ctrl = model_ctrl(instruction[31:26]);
        end
        if (flush) begin
            q.delete();
            m_valid = 1'b0;
        end else if (acc) begin
            if (q.size() > 0) void'(q.pop_front());
            q.push_back(e);
            m_valid = 1'b1;
        end else if (out_ready && m_valid) begin
            void'(q.pop_front());
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (wb_reg_write && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("reg_data1", reg_data1, q[0].d1);
            chk("reg_data2", reg_data2, q[0].d2);
            chk("imm_ext", imm_ext, q[0].imm);
            chk("pc_plus4_out", pc_plus4_out, q[0].pc);
            chk("rs", {27'd0, rs}, {27'd0, q[0].rs});
            chk("rt", {27'd0, rt}, {27'd0, q[0].rt});
            chk("rd", {27'd0, rd}, {27'd0, q[0].rd});
            chk("ctrl", {23'd0, dut_ctrl}, {23'd0, q[0].ctrl});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with busy inputs, including a writeback to r5.
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        present(32'h8C28_0004, 32'h0000_0100);
        wb_reg_write = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_reg_data1", reg_data1, 32'd0);
        chk("rst_reg_data2", reg_data2, 32'd0);
        chk("rst_imm_ext", imm_ext, 32'd0);
        chk("rst_pc", pc_plus4_out, 32'd0);
        chk("rst_fields", {17'd0, rs, rt, rd}, 32'd0);
        chk("rst_ctrl", {23'd0, dut_ctrl}, 32'd0);
        reset = 1'b1;
        wb_reg_write = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;

        // Read r5 after reset: add r4,r5,r0.
        present(32'h00A0_2020, 32'h0000_0104);
        tick();
        chk("r5_after_reset", reg_data1, 32'd0);

        // Writeback r3 in the same cycle as add r4,r3,r2.
        wb_reg_write = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_00AA;
        present(32'h0062_2020, 32'h0000_0108);
        tick();
        chk("bypass_r3", reg_data1, 32'h0000_00AA);
        chk("rtype_rd", {27'd0, rd}, 32'd4);
        chk("rtype_ctrl", {23'd0, dut_ctrl}, 32'h0000_010A);
        wb_reg_write = 1'b0;

        // Load-use: lw r8,4(r1) then add r9,r8,r2.
        present(32'h8C28_0004, 32'h0000_010C);
        tick();
        present(32'h0102_4820, 32'h0000_0110);
        #1;
        chk("load_use_stall", {31'd0, hazard_stall}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bubble", {31'd0, out_valid}, 32'd0);
        wb_reg_write = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_1234;
        tick();
        chk("add_after_bubble", reg_data1, 32'h0000_1234);
        wb_reg_write = 1'b0;

        // Backpressure for three cycles with addi r10,r0,0xFFF0 waiting.
        out_ready = 1'b0;
        present(32'h200A_FFF0, 32'h0000_0114);
        repeat (3) tick();
        chk("held_rd", {27'd0, rd}, 32'd9);
        out_ready = 1'b1;
        tick();
        chk("addi_sext", imm_ext, 32'hFFFF_FFF0);

        // Flush with a valid ID/EX entry and a valid incoming sw.
        out_ready = 1'b0;
        present(32'hAC22_0008, 32'h0000_0118);
        flush = 1'b1;
        tick();
        chk("flush_drop", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Load into r0 never stalls; r0 ignores writeback.
        present(32'h8C20_0000, 32'h0000_011C);
        tick();
        present(32'h0000_0020, 32'h0000_0120);
        wb_reg_write = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        chk("r0_reads_zero", reg_data1, 32'd0);
        wb_reg_write = 1'b0;

        // Remaining opcodes.
        present(32'h1022_0003, 32'h0000_0124); tick();
        present(32'hAC22_0008, 32'h0000_0128); tick();
        present(32'h340B_FFF0, 32'h0000_012C); tick();
`ifdef IDSTAGE_IMM_ZEXT_EN
        chk("ori_imm", imm_ext, 32'h0000_FFF0);
        chk("ori_aluop", {30'd0, ex_ALUOp_out}, 32'd3);
`else
        chk("ori_imm", imm_ext, 32'hFFFF_FFF0);
        chk("ori_nop", {23'd0, dut_ctrl}, 32'd0);
`endif
        present(32'h300B_8001, 32'h0000_0130); tick();
        present(32'hFC00_0000, 32'h0000_0134); tick();
        chk("unknown_valid", {31'd0, out_valid}, 32'd1);
        chk("unknown_nop", {23'd0, dut_ctrl}, 32'd0);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised successor to the decode stage. It decodes one instruction per handshake and holds an internal register file with write-through bypass. Results are registered into an ID/EX pipeline register with valid/ready flow control. Also detects load-use hazards (bubble insertion) and supports synchronous flush from branch resolution. Sits between IF/ID and the execute stage.

Parameters:
B, 32, data/instruction width (>=32; instruction fields taken from bits [31:0])
W, 5, register address width; register file depth 2^W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instruction available from IF/ID
in_ready  out  1  stage accepts instruction this cycle
instruction  in  B  instruction word
pc_plus4_in  in  B  incremented PC
flush  in  1  discard in-flight and incoming instruction
wb_reg_write  in  1  writeback enable
wb_addr  in  W  writeback register
wb_data  in  B  writeback data
out_valid  out  1  ID/EX register holds valid instruction
out_ready  in  1  execute stage consumes this cycle
reg_data1, reg_data2  out  B  rs/rt operands
imm_ext  out  B  extended immediate
rs, rt, rd  out  W  register fields
pc_plus4_out  out  B  registered PC+4
wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out  out  1  control
ex_ALUOp_out  out  2  ALU op class
hazard_stall  out  1  load-use stall active (combinational)

Behaviour:
- Reset (reset=0, async): all outputs registered in ID/EX go to 0; out_valid=0; all register-file entries go to 0.
- Register file: 2^W x B. Synchronous write on rising edge when wb_reg_write=1 and wb_addr!=0. Entry 0 always reads 0.
- Read bypass: when wb_reg_write=1, wb_addr!=0, and wb_addr equals rs/rt this cycle, the operand captured is wb_data.
- Decode (combinational; result captured on accept):
  - R 000000: RegWrite=1, RegDst=1, ALUOp=10.
  - LW 100011: RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=00.
  - SW 101011: MemWrite=1, ALUSrc=1, ALUOp=00.
  - BEQ 000100: Branch=1, ALUOp=01.
  - ADDI 001000: RegWrite=1, ALUSrc=1, ALUOp=00.
  - Any other opcode: all controls 0 (NOP); it is still passed with out_valid=1.
- imm_ext: sign extension of [15:0] to B bits. rs=[25:21], rt=[20:16], rd=[15:11].
- hazard_stall = in_valid & out_valid & m_MemRead_out & (rt_out!=0) & (rt_out==instr rs | rt_out==instr rt).
- in_ready = !hazard_stall & (!out_valid | out_ready), or 1 when flush=1.
- Accept = in_valid & in_ready & !flush. Latency is 1 cycle: the accepted instruction appears in ID/EX on the next edge.
- Register update priority:
  1. flush: out_valid<=0; incoming instruction dropped.
  2. accept: load ID/EX; out_valid<=1.
  3. out_ready & out_valid: out_valid<=0 (bubble; covers the hazard case).
  4. otherwise: hold all outputs.
- When out_valid=1 and out_ready=0, ID/EX outputs are stable.
- A load-use stall lasts exactly one cycle when out_ready=1.
- Register-file writes proceed regardless of stall or flush.

Optional Feature:
IDSTAGE_IMM_ZEXT_EN:
- Defined: ANDI 001100 and ORI 001101 decode as RegWrite=1, ALUSrc=1, ALUOp=11, with imm_ext zero-extended.
- Undefined: these opcodes are NOPs and imm_ext is always sign-extended.

Decomposition:
- Shared package id_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_LOGIC=11)
  - ctrl_t struct bundling the nine control fields
- One sub-module: id_regfile. It has two read ports, one write port, bypass, and async active-low clear.

Test Plan:
1. Reset check: hold reset=0 with arbitrary inputs -> all outputs 0, out_valid=0. Release reset; read r5 -> 0.
2. Write then R-type: wb writes r3=0x0000_00AA; same cycle, accept 0x0062_2020 (add r4,r3,r2) -> next cycle reg_data1=0xAA via bypass, RegDst=1, ALUOp=10, rd=4.
3. Load-use stall: lw r8,4(r1) is in ID/EX with out_ready=1, then add r9,r8,r2 is presented -> hazard_stall=1 and in_ready=0 for 1 cycle; a bubble follows; the add is accepted the next cycle.
4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ID/EX outputs unchanged, no instruction lost.
5. Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the instruction is dropped.
6. Immediate 0xFFF0 addi -> imm_ext=0xFFFF_FFF0. With IDSTAGE_IMM_ZEXT_EN, ori 0xFFF0 -> imm_ext=0x0000_FFF0, ALUOp=11.
